// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes RV32I ALU words, drives one-hot ALU enables and operands, writes results back
module alu_issue_ctrl #(
  parameter int XLEN      = 32,
  parameter bit ZERO_IDLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic            add_en,
  output logic            sub_en,
  output logic            sll_en,
  output logic            slt_en,
  output logic            sltu_en,
  output logic            xor_en,
  output logic            srl_en,
  output logic            sra_en,
  output logic            or_en,
  output logic            and_en,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] rd_data,
  output logic            retire_valid,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_data,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, WB, ERR} state_t;
  state_t state, state_nx;
  logic [XLEN-1:0] rf [32];
  logic [9:0] op_d, op_q;
  logic [4:0] rs1_q, rs2_q, rd_q;
  logic use_imm_q;
  logic [XLEN-1:0] imm_d, imm_q, res_q, rs1_h, rs2_h, rs1_live, rs2_live;
  logic is_r, is_i, shift, alt, legal, issue, accept;
  logic [2:0] f3;
  logic [6:0] f7;
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  // decode the presented word: legality, one-hot op, immediate operand
  always_comb begin
    is_r  = instr[6:0] == 7'b0110011;
    is_i  = instr[6:0] == 7'b0010011;
    shift = f3 == 3'b001 || f3 == 3'b101;
    alt   = f7 == 7'b0100000 && (f3 == 3'b101 || (is_r && f3 == 3'b000));
    legal = (is_r && (f7 == 7'b0 || alt)) || (is_i && (!shift || f7 == 7'b0 || alt));
    imm_d = shift ? {27'b0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
    op_d  = f3 == 3'b000 ? (alt ? 10'b0000000010 : 10'b0000000001) :
            f3 == 3'b001 ? 10'b0000000100 :
            f3 == 3'b010 ? 10'b0000001000 :
            f3 == 3'b011 ? 10'b0000010000 :
            f3 == 3'b100 ? 10'b0000100000 :
            f3 == 3'b101 ? (alt ? 10'b0010000000 : 10'b0001000000) :
            f3 == 3'b110 ? 10'b0100000000 : 10'b1000000000;
  end
  // next state and handshake/status outputs
  always_comb begin
    accept       = state == IDLE && instr_valid;
    issue        = state == ISSUE;
    state_nx     = state == IDLE ? (instr_valid ? (legal ? ISSUE : ERR) : IDLE) :
                   issue ? WB : IDLE;
    instr_ready  = state == IDLE;
    retire_valid = state == WB;
    illegal      = state == ERR;
    retire_rd    = retire_valid ? rd_q : 5'd0;
    retire_data  = retire_valid && rd_q != 5'd0 ? res_q : '0;
    {and_en, or_en, sra_en, srl_en, xor_en, sltu_en, slt_en, sll_en, sub_en, add_en} = issue ? op_q : 10'd0;
    rs1_live     = rf[rs1_q];
    rs2_live     = use_imm_q ? imm_q : rf[rs2_q];
    rs1_data     = issue ? rs1_live : ZERO_IDLE ? '0 : rs1_h;
    rs2_data     = issue ? rs2_live : ZERO_IDLE ? '0 : rs2_h;
    dbg_data     = dbg_addr == 5'd0 ? '0 : rf[dbg_addr];
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // latch decode on accept; capture ALU result and operands during ISSUE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      res_q     <= '0;
      rs1_h     <= '0;
      rs2_h     <= '0;
    end else begin
      if (accept) begin
        op_q      <= op_d;
        rs1_q     <= instr[19:15];
        rs2_q     <= instr[24:20];
        rd_q      <= instr[11:7];
        use_imm_q <= is_i;
        imm_q     <= imm_d;
      end
      if (issue) begin
        res_q <= rd_data;
        rs1_h <= rs1_live;
        rs2_h <= rs2_live;
      end
    end
  end
  // register file: cleared on reset, written in WB except x0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 32; k++) rf[k] <= '0;
    end else if (retire_valid && rd_q != 5'd0) rf[rd_q] <= res_q;
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized and directed checks of alu_issue_ctrl against an instruction-level model
module tb_alu_issue_ctrl;
  logic clk = 0, rst = 1, instr_valid = 0;
  logic [31:0] instr = 0, rd_data, rs1_data, rs2_data, retire_data, dbg_data;
  logic instr_ready, retire_valid, illegal;
  logic add_en, sub_en, sll_en, slt_en, sltu_en, xor_en, srl_en, sra_en, or_en, and_en;
  logic [4:0] retire_rd, dbg_addr = 0;
  logic [9:0] en;
  logic [31:0] m_rf [32];
  int n_cmp = 0, n_fail = 0;
  int base_op [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .add_en(add_en), .sub_en(sub_en), .sll_en(sll_en), .slt_en(slt_en), .sltu_en(sltu_en),
    .xor_en(xor_en), .srl_en(srl_en), .sra_en(sra_en), .or_en(or_en), .and_en(and_en),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_data(rd_data), .retire_valid(retire_valid),
    .retire_rd(retire_rd), .retire_data(retire_data), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  assign en = {and_en, or_en, sra_en, srl_en, xor_en, sltu_en, slt_en, sll_en, sub_en, add_en};

  function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a << b[4:0];
      3: return {31'b0, $signed(a) < $signed(b)};
      4: return {31'b0, a < b};
      5: return a ^ b;
      6: return a >> b[4:0];
      7: return $unsigned($signed(a) >>> b[4:0]);
      8: return a | b;
      default: return a & b;
    endcase
  endfunction

  // environment ALU mux driven by the DUT's enables
  always_comb begin
    rd_data = 0;
    for (int k = 0; k < 10; k++) if (en[k]) rd_data = alu_ref(k, rs1_data, rs2_data);
  end

  function automatic logic [31:0] r_w(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, s2, s1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] i_w(input logic [11:0] imm, input logic [4:0] s1, input logic [2:0] f3, input logic [4:0] rd);
    return {imm, s1, f3, rd, 7'h13};
  endfunction

  task automatic do_instr(input logic [31:0] w);
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [31:0] a, b, res;
    logic [4:0] probe;
    bit ok, sh;
    int op;
    f3 = w[14:12]; f7 = w[31:25]; rd = w[11:7];
    a = m_rf[w[19:15]]; b = 0; ok = 0; op = 0;
    if (w[6:0] == 7'h33) begin
      ok = f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
      b = m_rf[w[24:20]];
      op = base_op[f3] + int'(f7 == 7'h20);
    end else if (w[6:0] == 7'h13) begin
      sh = f3 == 1 || f3 == 5;
      ok = !sh || f7 == 0 || (f3 == 5 && f7 == 7'h20);
      b = sh ? {27'b0, w[24:20]} : {{20{w[31]}}, w[31:20]};
      op = base_op[f3] + int'(f3 == 5 && f7 == 7'h20);
    end
    res = alu_ref(op, a, b);
    @(negedge clk);
    instr = w; instr_valid = 1;
    n_cmp++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL ready_idle w=%h got %b want 1", w, instr_ready); end
    @(posedge clk); #1;
    instr = $urandom;
    if (ok) begin
      n_cmp++; if (en !== 10'(1 << op)) begin n_fail++; $display("FAIL issue_en w=%h got %b want %b", w, en, 10'(1 << op)); end
      n_cmp++; if (rs1_data !== a) begin n_fail++; $display("FAIL issue_rs1 w=%h got %h want %h", w, rs1_data, a); end
      n_cmp++; if (rs2_data !== b) begin n_fail++; $display("FAIL issue_rs2 w=%h got %h want %h", w, rs2_data, b); end
      n_cmp++; if ({instr_ready, retire_valid, illegal} !== 3'b000) begin n_fail++; $display("FAIL issue_status w=%h got %b want 000", w, {instr_ready, retire_valid, illegal}); end
      @(posedge clk); #1;
      instr_valid = 0;
      n_cmp++; if (retire_valid !== 1'b1 || retire_rd !== rd) begin n_fail++; $display("FAIL retire_rd w=%h got %b/%0d want 1/%0d", w, retire_valid, retire_rd, rd); end
      n_cmp++; if (retire_data !== (rd == 0 ? 32'h0 : res)) begin n_fail++; $display("FAIL retire_data w=%h got %h want %h", w, retire_data, rd == 0 ? 32'h0 : res); end
      n_cmp++; if (en !== 10'd0 || rs1_data !== 0 || rs2_data !== 0) begin n_fail++; $display("FAIL wb_quiet w=%h got en=%b rs1=%h rs2=%h want 0", w, en, rs1_data, rs2_data); end
      if (rd != 0) m_rf[rd] = res;
      probe = rd;
    end else begin
      n_cmp++; if (illegal !== 1'b1 || en !== 10'd0) begin n_fail++; $display("FAIL illegal_pulse w=%h got ill=%b en=%b want 1/0", w, illegal, en); end
      n_cmp++; if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_retire w=%h got %b want 0", w, retire_valid); end
      instr_valid = 0;
      probe = 5'($urandom);
    end
    @(posedge clk); #1;
    dbg_addr = probe;
    n_cmp++; if ({instr_ready, retire_valid, illegal} !== 3'b100) begin n_fail++; $display("FAIL back_idle w=%h got %b want 100", w, {instr_ready, retire_valid, illegal}); end
    #1;
    n_cmp++; if (dbg_data !== m_rf[probe]) begin n_fail++; $display("FAIL dbg_after x%0d got %h want %h", probe, dbg_data, m_rf[probe]); end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (en !== 10'd0 || rs1_data !== 0 || rs2_data !== 0) begin n_fail++; $display("FAIL reset_ops got en=%b rs1=%h rs2=%h want 0", en, rs1_data, rs2_data); end
    n_cmp++; if ({retire_valid, retire_rd, retire_data, illegal} !== 39'd0) begin n_fail++; $display("FAIL reset_retire got %b %h %h %b want 0", retire_valid, retire_rd, retire_data, illegal); end
    n_cmp++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", instr_ready); end
    for (int k = 0; k < 32; k++) begin
      dbg_addr = 5'(k); #1;
      n_cmp++; if (dbg_data !== 0) begin n_fail++; $display("FAIL reset_rf x%0d got %h want 0", k, dbg_data); end
    end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_basic;
    do_instr(i_w(12'd5, 0, 3'b000, 1));
    do_instr(i_w(12'd6, 0, 3'b000, 2));
    do_instr(r_w(7'h00, 2, 1, 3'b000, 3));
    dbg_addr = 3; #1;
    n_cmp++; if (dbg_data !== 32'hB) begin n_fail++; $display("FAIL add_x3 got %h want 0000000b", dbg_data); end
  endtask

  task automatic test_sub_sra_slt;
    do_instr(r_w(7'h20, 2, 1, 3'b000, 4));
    dbg_addr = 4; #1;
    n_cmp++; if (dbg_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL sub_x4 got %h want ffffffff", dbg_data); end
    do_instr(i_w(12'h403, 4, 3'b101, 5));
    do_instr(i_w(12'hFFF, 0, 3'b010, 6));
    dbg_addr = 6; #1;
    n_cmp++; if (dbg_data !== 32'h0) begin n_fail++; $display("FAIL slti_x6 got %h want 0", dbg_data); end
  endtask

  task automatic test_illegal;
    do_instr(r_w(7'h01, 2, 1, 3'b000, 8));
    do_instr(32'h0);
    do_instr(i_w(12'h405, 1, 3'b001, 9));
    do_instr(r_w(7'h20, 2, 1, 3'b111, 10));
    do_instr(r_w(7'h00, 2, 1, 3'b000, 11) & 32'hFFFF_FFFE);
    dbg_addr = 8; #1;
    n_cmp++; if (dbg_data !== 32'h0) begin n_fail++; $display("FAIL illegal_nowrite got %h want 0", dbg_data); end
  endtask

  task automatic test_x0;
    do_instr(r_w(7'h00, 2, 1, 3'b000, 0));
    dbg_addr = 0; #1;
    n_cmp++; if (dbg_data !== 32'h0) begin n_fail++; $display("FAIL x0_read got %h want 0", dbg_data); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    instr = r_w(7'h00, 2, 1, 3'b000, 7); instr_valid = 1;
    @(posedge clk); #1;
    instr_valid = 0;
    n_cmp++; if (en !== 10'b1) begin n_fail++; $display("FAIL mid_issue got %b want 0000000001", en); end
    #2 rst = 1; #1;
    n_cmp++; if (en !== 10'd0 || retire_valid !== 1'b0) begin n_fail++; $display("FAIL mid_drop got en=%b rv=%b want 0/0", en, retire_valid); end
    for (int k = 0; k < 32; k++) m_rf[k] = 0;
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    n_cmp++; if (instr_ready !== 1'b1 || retire_valid !== 1'b0) begin n_fail++; $display("FAIL mid_release got rdy=%b rv=%b want 1/0", instr_ready, retire_valid); end
    dbg_addr = 7; #1;
    n_cmp++; if (dbg_data !== 0) begin n_fail++; $display("FAIL mid_x7 got %h want 0", dbg_data); end
    dbg_addr = 1; #1;
    n_cmp++; if (dbg_data !== 0) begin n_fail++; $display("FAIL mid_x1 got %h want 0", dbg_data); end
  endtask

  task automatic test_random;
    logic [6:0] f7, opc;
    logic [31:0] w;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0, 1: f7 = 7'h00;
        2: f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0, 1, 2, 3: opc = 7'h33;
        4, 5, 6, 7: opc = 7'h13;
        default: opc = 7'($urandom);
      endcase
      w = {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
      do_instr(w);
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) m_rf[k] = 0;
    test_reset;
    test_basic;
    test_sub_sra_slt;
    test_illegal;
    test_x0;
    test_random;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
